dircc_stream_packet_buffer: RTL and testbench
=============================================

Name: dircc_stream_packet_buffer

Overview:
- Parametrised store-and-forward packet buffer between the routing fabric and a processing node's stream ports.
- Accepts Avalon-ST packets and filters them on a header destination address: local address or broadcast is kept, anything else is dropped.
- Releases only complete, committed packets downstream.
- Generalises the fixed 32-bit single-channel node stream interface with configurable width, depth and filtering.

Parameters:
DATA_W, 32, stream data width in bits; must be at least 32 (header occupies bits [31:0]).
EMPTY_W, 2, width of the empty field.
DEPTH, 64, buffer depth in words; power of 2, minimum 4.
BCAST_ADDR, 32'hFFFF_FFFF, header value accepted by every node.

Ports:
clk_clk  in  1  single clock
reset_reset  in  1  synchronous, active-high reset
address_address  in  32  this node's address; sampled at each sop
stream_in_valid  in  1  input beat valid
stream_in_data  in  DATA_W  input data; bits [31:0] of the sop beat are the destination header
stream_in_startofpacket  in  1  first beat of packet
stream_in_endofpacket  in  1  last beat of packet
stream_in_empty  in  EMPTY_W  empty symbols on the eop beat
stream_in_ready  out  1  buffer can accept a beat
stream_out_valid  out  1  output beat valid
stream_out_data  out  DATA_W  output data
stream_out_startofpacket  out  1  first beat of packet
stream_out_endofpacket  out  1  last beat of packet
stream_out_empty  out  EMPTY_W  empty symbols on the eop beat
stream_out_ready  in  1  downstream accepts the beat
pkt_count  out  $clog2(DEPTH)+1  number of committed packets not yet fully read
drop_pulse  out  1  one-cycle pulse for each dropped packet

Behaviour:
- Reset (synchronous, active-high):
  - All pointers and counters clear to 0; write FSM goes to IDLE.
  - stream_in_ready=0 while reset_reset=1, and 1 from the first cycle after reset deasserts.
  - stream_out_valid=0, all stream_out_* data/sideband=0, pkt_count=0, drop_pulse=0.
- Storage:
  - RAM words are {sop, eop, empty, data}.
  - Three pointers: wr_ptr (speculative), commit_ptr, rd_ptr.
  - Each pointer is $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty on wrap.
- Write FSM states: IDLE, ACCEPT, DROP. A beat is accepted when stream_in_valid & stream_in_ready.
  - IDLE, sop beat:
    - Header matches address_address or BCAST_ADDR: store the beat and go to ACCEPT.
    - Otherwise go to DROP.
    - Non-sop beats in IDLE are discarded without a drop_pulse.
  - ACCEPT: store each beat. On the eop beat, commit_ptr <= wr_ptr+1 and pkt_count increments the next cycle; return to IDLE.
  - DROP: stream_in_ready=1; beats are discarded. On eop, return to IDLE and drop_pulse=1 for one cycle.
  - sop+eop on the same beat is a one-word packet: commit (if matched) or drop immediately; stay in IDLE.
  - sop received while in ACCEPT (missing eop):
    - Roll back wr_ptr <= commit_ptr and pulse drop_pulse.
    - Evaluate the new sop as in IDLE during the same cycle.
  - Buffer full in ACCEPT:
    - If committed data is outstanding (commit_ptr != rd_ptr): stream_in_ready=0 (backpressure) until space frees.
    - Otherwise the packet exceeds DEPTH: roll back wr_ptr <= commit_ptr, pulse drop_pulse, go to DROP.
  - stream_in_ready=0 only when the FSM is in ACCEPT or IDLE and the buffer is full.
- Read side:
  - Show-ahead output register, valid whenever rd_ptr != commit_ptr.
  - First beat of a packet committed at cycle N is valid at the earliest at N+2.
  - Beat transfers on stream_out_valid & stream_out_ready. Output data/sideband hold stable while valid & !ready.
  - pkt_count decrements on the cycle after an eop beat transfers out.
  - Simultaneous commit and read-eop leave pkt_count unchanged.
- Full throughput: one beat per cycle in and out concurrently when the buffer is neither full nor empty.

Optional Feature:
- DIRCC_PKT_DROP_CNT_EN defined:
  - Adds output drop_count [15:0]; increments on each drop_pulse, saturates at 16'hFFFF, clears on reset.
  - Adds input drop_count_clr, which clears the counter synchronously; a clear in the same cycle as a drop yields 0.
- Macro undefined: neither port exists; drop_pulse behaviour is unchanged.

Test Plan:
- Reset, then 4-beat packet with header=address_address=32'h0000_0005 and ready=1 -> identical 4 beats out, sop on beat 0, eop+empty on beat 3, pkt_count 1->0.
- Packet with header 32'h0000_0009, address 5 -> nothing output, drop_pulse high for 1 cycle on the eop cycle; header 32'hFFFF_FFFF -> forwarded.
- DEPTH=8, stream_out_ready=0, two 4-word packets -> stream_in_ready=0 after 8 words, pkt_count=2; ready=1 -> both packets out in order.
- DEPTH=8, 10-word matched packet, buffer empty -> rolled back, drop_pulse=1, output stays idle; a following 2-word packet is forwarded intact.
- sop, 2 beats, then a new sop without eop -> first partial packet discarded with drop_pulse=1; second packet delivered complete.
- Reset asserted mid-packet in ACCEPT -> next cycle pkt_count=0, stream_out_valid=0; a fresh packet afterwards passes normally.

Source files
------------

// File: rtl/dircc_stream_packet_buffer_if.sv
// Avalon-ST stream bundle used on both the fabric side and the node side of the packet buffer.
interface dircc_stream_packet_buffer_if #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
);
    logic               valid;
    logic               ready;
    logic [DATA_W-1:0]  data;
    logic               startofpacket;
    logic               endofpacket;
    logic [EMPTY_W-1:0] empty;

    modport master (output valid, data, startofpacket, endofpacket, empty, input ready);
    modport slave  (input valid, data, startofpacket, endofpacket, empty, output ready);
endinterface

// File: rtl/dircc_stream_packet_buffer.sv
// Store-and-forward packet buffer with destination filtering; only committed packets are released.
// Optional DIRCC_PKT_DROP_CNT_EN adds a saturating drop counter with synchronous clear.
module dircc_stream_packet_buffer #(
    parameter int          DATA_W     = 32,
    parameter int          EMPTY_W    = 2,
    parameter int          DEPTH      = 64,
    parameter logic [31:0] BCAST_ADDR = 32'hFFFF_FFFF
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic [31:0]                  address_address,
    dircc_stream_packet_buffer_if.slave  stream_in,
    dircc_stream_packet_buffer_if.master stream_out,
    output logic [$clog2(DEPTH):0]       pkt_count,
    output logic                         drop_pulse
`ifdef DIRCC_PKT_DROP_CNT_EN
    ,
    output logic [15:0]                  drop_count,
    input  logic                         drop_count_clr
`endif
);
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;
    localparam int WORD_W = DATA_W + EMPTY_W + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    // state  | meaning
    // IDLE   | between packets, waiting for a sop
    // ACCEPT | storing a matched packet speculatively past commit_ptr
    // DROP   | discarding beats until eop
    typedef enum logic [1:0] {IDLE, ACCEPT, DROP} state_t;

    state_t            state;
    logic              drop_quiet;
    logic [PW-1:0]     wr_ptr, commit_ptr, rd_ptr, rd_next;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] in_word, rd_word;
    logic              full, in_ready, in_fire, hdr_match, sop_ok, overflow;
    logic              commit_now, mem_we, out_fire, out_eop_fire;
    logic [AW-1:0]     mem_waddr;

    assign in_word   = {stream_in.startofpacket, stream_in.endofpacket, stream_in.empty, stream_in.data};
    assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
    assign in_ready  = !reset_reset && !(state != DROP && full);
    assign stream_in.ready = in_ready;
    assign in_fire   = stream_in.valid && in_ready;
    assign hdr_match = (stream_in.data[31:0] == address_address) || (stream_in.data[31:0] == BCAST_ADDR);
    // A sop seen in ACCEPT aborts the open packet and is then judged exactly like one seen in IDLE.
    assign sop_ok    = in_fire && stream_in.startofpacket && (state != DROP);
    assign overflow  = (state == ACCEPT) && full && (commit_ptr == rd_ptr);
    assign commit_now = in_fire && stream_in.endofpacket &&
                        ((sop_ok && hdr_match) || (state == ACCEPT && !stream_in.startofpacket));
    assign mem_we    = (sop_ok && hdr_match) || (in_fire && state == ACCEPT && !stream_in.startofpacket);
    assign mem_waddr = stream_in.startofpacket ? commit_ptr[AW-1:0] : wr_ptr[AW-1:0];

    always_ff @(posedge clk_clk) begin
        if (mem_we) mem[mem_waddr] <= in_word;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            drop_pulse <= 1'b0;
            drop_quiet <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (sop_ok) begin
                if (state == ACCEPT) drop_pulse <= 1'b1;
                if (hdr_match) begin
                    wr_ptr <= commit_ptr + ONE_P;
                    if (stream_in.endofpacket) begin
                        commit_ptr <= commit_ptr + ONE_P;
                        state      <= IDLE;
                    end else begin
                        state <= ACCEPT;
                    end
                end else begin
                    wr_ptr <= commit_ptr;
                    if (stream_in.endofpacket) begin
                        drop_pulse <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        drop_quiet <= 1'b0;
                        state      <= DROP;
                    end
                end
            end else begin
                case (state)
                    ACCEPT: begin
                        // Oversized packet: already reported here, so its later eop stays silent.
                        if (overflow) begin
                            wr_ptr     <= commit_ptr;
                            drop_pulse <= 1'b1;
                            drop_quiet <= 1'b1;
                            state      <= DROP;
                        end else if (in_fire) begin
                            wr_ptr <= wr_ptr + ONE_P;
                            if (stream_in.endofpacket) begin
                                commit_ptr <= wr_ptr + ONE_P;
                                state      <= IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (in_fire && stream_in.endofpacket) begin
                            drop_pulse <= !drop_quiet;
                            state      <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_fire     = stream_out.valid && stream_out.ready;
    assign out_eop_fire = out_fire && stream_out.endofpacket;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pkt_count <= '0;
        end else if (commit_now && !out_eop_fire) begin
            pkt_count <= pkt_count + ONE_P;
        end else if (!commit_now && out_eop_fire) begin
            pkt_count <= pkt_count - ONE_P;
        end
    end

    // rd_ptr only advances on a transfer, so the output register always mirrors mem[rd_ptr].
    assign rd_next = out_fire ? rd_ptr + ONE_P : rd_ptr;
    assign rd_word = mem[rd_next[AW-1:0]];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rd_ptr                   <= '0;
            stream_out.valid         <= 1'b0;
            stream_out.startofpacket <= 1'b0;
            stream_out.endofpacket   <= 1'b0;
            stream_out.empty         <= '0;
            stream_out.data          <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (rd_next != commit_ptr) begin
                stream_out.valid <= 1'b1;
                {stream_out.startofpacket, stream_out.endofpacket,
                 stream_out.empty, stream_out.data} <= rd_word;
            end else begin
                stream_out.valid <= 1'b0;
            end
        end
    end

`ifdef DIRCC_PKT_DROP_CNT_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset || drop_count_clr) begin
            drop_count <= '0;
        end else if (drop_pulse && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dircc_stream_packet_buffer.sv
// Bench for dircc_stream_packet_buffer: directed cases plus random packets against a queue-based model.
module tb_dircc_stream_packet_buffer;
    localparam int DATA_W  = 36;
    localparam int EMPTY_W = 2;
    localparam int DEPTH   = 8;
    localparam int WORD_W  = DATA_W + EMPTY_W + 2;
    localparam logic [31:0] NODE  = 32'h0000_0005;
    localparam logic [31:0] BCAST = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] addr;
    logic [$clog2(DEPTH):0] pkt_count;
    logic drop_pulse;
`ifdef DIRCC_PKT_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    dircc_stream_packet_buffer_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) in_if ();
    dircc_stream_packet_buffer_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) out_if ();

    always #5 clk = ~clk;

    dircc_stream_packet_buffer #(
        .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH), .BCAST_ADDR(BCAST)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .address_address(addr),
        .stream_in(in_if),
        .stream_out(out_if),
        .pkt_count(pkt_count),
        .drop_pulse(drop_pulse)
`ifdef DIRCC_PKT_DROP_CNT_EN
        ,
        .drop_count(drop_count),
        .drop_count_clr(1'b0)
`endif
    );

    int total = 0;
    int bad = 0;
    logic [WORD_W-1:0] exp_q[$];
    int mdl_pkt = 0;
    int exp_drops = 0;
    int act_drops = 0;
    bit cur_fwd = 1'b0;
    bit rand_ready = 1'b0;
    logic dir_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    initial begin
        out_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_if.ready = rand_ready ? ($urandom_range(0, 3) != 0) : dir_ready;
        end
    end

    // Compare process: everything sampled at negedge, mid-cycle.
    initial begin
        logic [WORD_W-1:0] held, out_word;
        bit prev_rst, prev_hold;
        prev_rst = 1'b0;
        prev_hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            out_word = {out_if.startofpacket, out_if.endofpacket, out_if.empty, out_if.data};
            if (rst) begin
                chk("ready_in_reset", in_if.ready, 0);
                mdl_pkt = 0;
                exp_q.delete();
                prev_rst = 1'b1;
                prev_hold = 1'b0;
            end else begin
                if (prev_rst) begin
                    chk("valid_after_reset", out_if.valid, 0);
                    chk("ready_after_reset", in_if.ready, 1);
                    chk("drop_after_reset", drop_pulse, 0);
                end
                chk("pkt_count", pkt_count, mdl_pkt);
                if (prev_hold) begin
                    chk("hold_valid", out_if.valid, 1);
                    chk("hold_word", out_word, held);
                end
                if (drop_pulse) act_drops++;
                if (out_if.valid && out_if.ready) begin
                    chk("out_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("out_word", out_word, exp_q.pop_front());
                    if (out_if.endofpacket) mdl_pkt--;
                end
                if (in_if.valid && in_if.ready && in_if.endofpacket && cur_fwd) mdl_pkt++;
                prev_hold = out_if.valid && !out_if.ready;
                held = out_word;
                prev_rst = 1'b0;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, want test end");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [WORD_W-1:0] w);
        int n;
        {in_if.startofpacket, in_if.endofpacket, in_if.empty, in_if.data} = w;
        in_if.valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_if.ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("in_ready_timeout", in_if.ready, 1);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int len, input bit trunc, input int max_gap);
        logic [WORD_W-1:0] w;
        logic [DATA_W-1:0] d;
        logic [EMPTY_W-1:0] emp;
        logic e;
        bit fwd;
        fwd = ((hdr == addr) || (hdr == BCAST)) && (len <= DEPTH) && !trunc;
        if (!fwd) exp_drops++;
        cur_fwd = fwd;
        for (int i = 0; i < len; i++) begin
            d = DATA_W'({$urandom(), $urandom()});
            if (i == 0) d[31:0] = hdr;
            e = (i == len - 1) && !trunc;
            emp = e ? EMPTY_W'($urandom()) : '0;
            w = {(i == 0), e, emp, d};
            if (fwd) exp_q.push_back(w);
            drive_beat(w);
            if (max_gap > 0) gap($urandom_range(0, max_gap));
        end
    endtask

    task automatic stray();
        logic [WORD_W-1:0] w;
        cur_fwd = 1'b0;
        w = {1'b0, 1'($urandom()), {EMPTY_W{1'b0}}, DATA_W'({$urandom(), $urandom()})};
        drive_beat(w);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_if.valid) && n < 3000) begin
            gap(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int a0, len, r;
        bit tr, prev_tr;
        logic [31:0] h;
        rst = 1'b1;
        addr = NODE;
        in_if.valid = 1'b0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket = 1'b0;
        in_if.empty = '0;
        in_if.data = '0;
        gap(3);
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_data", out_if.data, 0);
        chk("rst_out_sop", out_if.startofpacket, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_in_ready", in_if.ready, 1);
        gap(1);

        // matched 4-beat packet held at the output, then released
        dir_ready = 1'b0;
        send_pkt(NODE, 4, 1'b0, 0);
        gap(3);
        @(negedge clk);
        chk("t1_pkt_count", pkt_count, 1);
        chk("t1_sop", out_if.startofpacket, 1);
        chk("t1_hdr", out_if.data[31:0], 32'h0000_0005);
        gap(1);
        dir_ready = 1'b1;
        wait_drain("t1_drain");
        @(negedge clk);
        chk("t1_pkt_zero", pkt_count, 0);
        gap(1);

        // foreign header dropped, broadcast forwarded
        a0 = act_drops;
        send_pkt(32'h0000_0009, 3, 1'b0, 0);
        gap(4);
        chk("t2_drop", act_drops - a0, 1);
        chk("t2_no_out", out_if.valid, 0);
        send_pkt(BCAST, 2, 1'b0, 0);
        wait_drain("t2_bcast");

        // two 4-word packets fill DEPTH=8 while downstream stalls
        dir_ready = 1'b0;
        gap(1);
        send_pkt(NODE, 4, 1'b0, 0);
        send_pkt(NODE, 4, 1'b0, 0);
        gap(3);
        @(negedge clk);
        chk("t3_in_ready", in_if.ready, 0);
        chk("t3_pkt_count", pkt_count, 2);
        gap(1);
        dir_ready = 1'b1;
        wait_drain("t3_drain");

        // oversized packet rolled back, next packet intact
        a0 = act_drops;
        send_pkt(NODE, 10, 1'b0, 0);
        gap(4);
        chk("t4_drop", act_drops - a0, 1);
        chk("t4_no_out", out_if.valid, 0);
        send_pkt(NODE, 2, 1'b0, 0);
        wait_drain("t4_next");

        // missing eop: partial packet discarded when the next sop arrives
        a0 = act_drops;
        send_pkt(NODE, 3, 1'b1, 0);
        send_pkt(NODE, 3, 1'b0, 0);
        gap(4);
        chk("t5_drop", act_drops - a0, 1);
        wait_drain("t5_next");

        // reset in the middle of a packet with a committed one pending
        dir_ready = 1'b0;
        gap(1);
        send_pkt(NODE, 2, 1'b0, 0);
        cur_fwd = 1'b0;
        drive_beat({1'b1, 1'b0, {EMPTY_W{1'b0}}, {4'h3, NODE}});
        drive_beat({1'b0, 1'b0, {EMPTY_W{1'b0}}, 36'h1_2345_6789});
        rst = 1'b1;
        gap(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_pkt_count", pkt_count, 0);
        chk("t6_out_valid", out_if.valid, 0);
        gap(1);
        dir_ready = 1'b1;
        send_pkt(NODE, 3, 1'b0, 0);
        wait_drain("t6_fresh");

        // random traffic with random downstream stalls
        rand_ready = 1'b1;
        prev_tr = 1'b0;
        for (int p = 0; p < 250; p++) begin
            r = $urandom_range(0, 9);
            h = (r < 5) ? addr : (r < 7) ? BCAST : 32'($urandom_range(0, 15));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH + 1, DEPTH + 4)
                                              : $urandom_range(1, DEPTH);
            if (prev_tr && len < 2) len = 2;
            tr = !prev_tr && ((h == addr) || (h == BCAST)) && (len < DEPTH) &&
                 ($urandom_range(0, 7) == 0);
            send_pkt(h, len, tr, 2);
            prev_tr = tr;
            if (!tr && $urandom_range(0, 7) == 0) stray();
        end
        send_pkt(addr, 2, 1'b0, 1);
        wait_drain("rand_drain");
        gap(4);
        chk("drop_total", act_drops, exp_drops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
